pwm_bank: RTL and testbench
===========================

PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 PWM_NUM, 4, number of PWM channels, 1..255.
REQ-002 CNT_W, 28, counter/threshold width, 8..32.
REQ-003 ID_PWM_PARAM, 0, 8-bit frame ID accepted by the parser.
REQ-004 clk  input  1  module clock; all logic is synchronous to its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 rx_axis_udp_tdata  input  32  UDP payload word.
REQ-007 rx_axis_udp_tvalid  input  1  payload word valid; no backpressure, the block always accepts.
REQ-008 rx_axis_udp_tlast  input  1  last word of frame.
REQ-009 pwm_sync  input  1  single-cycle pulse that restarts all enabled channels at their phase.
REQ-010 cfg_ack  output  1  one-cycle pulse: a valid frame was latched into the shadow register(s).
REQ-011 cfg_err  output  1  one-cycle pulse: frame discarded.
REQ-012 pwm  output  PWM_NUM  PWM outputs.

Function
REQ-013 Frame: four words, with tlast only on word 3.
  - Word 0: [31:24] ID, [23:16] channel, [16+... ] not used; [8] en, [9] mode (0 = edge, 1 = center), [10] invert, other bits ignored.
  - Word 1: period. Word 2: hlevel. Word 3: phase. Each value is in bits [CNT_W-1:0]; upper bits are ignored.
REQ-014 The parser SHALL be a state machine with states W0, W1, W2, W3 and DROP.
  - Each valid word advances the state.
  - A word-0 ID mismatch moves the parser to DROP.
  - DROP returns to W0 on the valid tlast word.
REQ-015 A frame SHALL be discarded, with cfg_err pulsed one cycle after its tlast word, if any of the following holds:
  - tlast arrives before word 3;
  - word 3 arrives without tlast (the parser then waits in DROP for tlast);
  - the channel is at or above PWM_NUM and is not 0xFF.
REQ-016 An ID mismatch SHALL be dropped silently, with no cfg_err.
REQ-017 On a valid word 3, the fields SHALL be written to the shadow register of the addressed channel, or of all channels if the channel is 0xFF. cfg_ack SHALL pulse on the next cycle and the pending flag(s) SHALL be set.
REQ-018 A later frame arriving while a channel is still pending SHALL overwrite that channel's shadow register; only the last frame is applied.
REQ-019 Edge mode: the counter runs 0..period-1 and wraps to 0. The raw output is high while cnt < hlevel.
REQ-020 Center mode: the counter runs up 0..period-1, then down period-1..0, so one cycle is 2*period clocks. The raw output is high while cnt < hlevel.
REQ-021 pwm[i] = en & (raw XOR invert).
  - While en = 0, pwm[i] = 0 and the counter is held at 0.
REQ-022 Threshold boundaries:
  - hlevel = 0: output 0% (raw low).
  - hlevel >= period: output 100% (raw high).
  - period = 0: the channel is treated as disabled and pwm[i] = 0.
REQ-023 A pending update SHALL be applied at the period boundary:
  - edge mode: cycle where cnt = period-1;
  - center mode: down-count cycle where cnt = 0.
  The counter SHALL then load (phase mod period) on the next clock and the pending flag SHALL clear.
REQ-024 If the active en = 0, a pending update SHALL be applied on the clock after cfg_ack.
REQ-025 Phase loading:
  - phase >= period SHALL be reduced by one conditional subtraction of period; if the value is still >= period, 0 is used.
  - Center mode SHALL start counting up.
REQ-026 pwm_sync SHALL load every enabled channel's counter with its phase on the next clock.
  - If an update is pending on the same cycle, the new shadow values SHALL be applied first and the new phase loaded.
REQ-027 pwm SHALL be registered, with one clock of latency from the counter compare to the pin.
REQ-028 No combinational path SHALL exist from any input to any output.

Reset
REQ-029 While rst = 0, the following SHALL hold:
  - pwm = 0, cfg_ack = 0, cfg_err = 0;
  - parser in W0;
  - all active and shadow registers cleared (en = 0, period = 0, hlevel = 0, phase = 0, mode = 0, invert = 0);
  - pending flags cleared, counters at 0.
REQ-030 Reset asserted mid-frame or mid-period SHALL abort the operation. After release, the first frame SHALL be parsed from word 0.

Verification
REQ-031 Frame ch0: en=1, edge, period=10, hlevel=3, phase=0 -> cfg_ack one cycle after tlast; pwm[0] repeats 3 clocks high / 7 clocks low.
REQ-032 While ch0 is running, frame hlevel=7 -> the current period finishes at 3/10, and the next period is 7/10 with no glitch.
REQ-033 Broadcast (0xFF): center mode, period=8, hlevel=2, invert=1 -> every pwm[i] runs a 16-clock cycle and is low for 4 clocks centered on the wrap.
REQ-034 Ch1 phase=5, ch0 phase=0, both period=10, then pwm_sync -> pwm[1] leads pwm[0] by 5 clocks.
REQ-035 Error frames:
  - tlast on word 1 -> cfg_err, no state change.
  - Channel = PWM_NUM -> cfg_err.
  - Wrong ID -> no ack and no err.
  - A following good frame is accepted.
REQ-036 Boundary values and reset:
  - hlevel=0 -> constant 0; hlevel=period -> constant 1; period=0 -> constant 0.
  - Reset asserted mid-frame -> all outputs 0, then the next frame is accepted.

Source files
------------

// File: rtl/pwm_bank.sv
// PWM bank: UDP frame parser loading per-channel shadow registers,
// with edge/center counters that take updates at period boundaries.
module pwm_bank #(
    parameter int         PWM_NUM      = 4,
    parameter int         CNT_W        = 28,
    parameter logic [7:0] ID_PWM_PARAM = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        rx_axis_udp_tdata,
    input  logic               rx_axis_udp_tvalid,
    input  logic               rx_axis_udp_tlast,
    input  logic               pwm_sync,
    output logic               cfg_ack,
    output logic               cfg_err,
    output logic [PWM_NUM-1:0] pwm
);

    typedef enum logic [2:0] {W0, W1, W2, W3, DROP} state_t;

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [8:0]       NUM9 = 9'(PWM_NUM);

    state_t           state, state_nx;
    logic             drop_err, drop_err_nx;
    logic             ack_nx, err_nx, commit;
    logic [7:0]       f_ch;
    logic             f_en, f_mode, f_inv;
    logic [CNT_W-1:0] f_per, f_hl, word_val;
    logic             id_hit, ch_ok, bcast;
    logic             unused_bits;

    assign word_val    = rx_axis_udp_tdata[CNT_W-1:0];
    assign id_hit      = rx_axis_udp_tdata[31:24] == ID_PWM_PARAM;
    assign bcast       = f_ch == 8'hFF;
    assign ch_ok       = bcast || ({1'b0, f_ch} < NUM9);
    assign unused_bits = ^{rx_axis_udp_tdata[15:11], rx_axis_udp_tdata[7:0]};

    // Phase folded into range with a single conditional subtraction.
    function automatic logic [CNT_W-1:0] ph_mod(
        input logic [CNT_W-1:0] ph,
        input logic [CNT_W-1:0] per
    );
        logic [CNT_W-1:0] r;
        r = ph;
        if (r >= per) r = r - per;
        if (r >= per) r = '0;
        return r;
    endfunction

    always_comb begin
        state_nx    = state;
        drop_err_nx = drop_err;
        ack_nx      = 1'b0;
        err_nx      = 1'b0;
        commit      = 1'b0;
        if (rx_axis_udp_tvalid) begin
            unique case (state)
                W0: begin
                    drop_err_nx = 1'b0;
                    if (!id_hit)
                        state_nx = rx_axis_udp_tlast ? W0 : DROP;
                    else if (rx_axis_udp_tlast)
                        err_nx = 1'b1;
                    else
                        state_nx = W1;
                end
                W1, W2: begin
                    if (rx_axis_udp_tlast) begin
                        err_nx   = 1'b1;
                        state_nx = W0;
                    end else begin
                        state_nx = (state == W1) ? W2 : W3;
                    end
                end
                W3: begin
                    if (rx_axis_udp_tlast) begin
                        state_nx = W0;
                        commit   = ch_ok;
                        ack_nx   = ch_ok;
                        err_nx   = !ch_ok;
                    end else begin
                        state_nx    = DROP;
                        drop_err_nx = 1'b1;
                    end
                end
                DROP: begin
                    if (rx_axis_udp_tlast) begin
                        state_nx    = W0;
                        err_nx      = drop_err;
                        drop_err_nx = 1'b0;
                    end
                end
                default: state_nx = W0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= W0;
            drop_err <= 1'b0;
            cfg_ack  <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            drop_err <= drop_err_nx;
            cfg_ack  <= ack_nx;
            cfg_err  <= err_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_ch   <= '0;
            f_en   <= 1'b0;
            f_mode <= 1'b0;
            f_inv  <= 1'b0;
            f_per  <= '0;
            f_hl   <= '0;
        end else if (rx_axis_udp_tvalid) begin
            if (state == W0) begin
                f_ch   <= rx_axis_udp_tdata[23:16];
                f_en   <= rx_axis_udp_tdata[8];
                f_mode <= rx_axis_udp_tdata[9];
                f_inv  <= rx_axis_udp_tdata[10];
            end
            if (state == W1) f_per <= word_val;
            if (state == W2) f_hl  <= word_val;
        end
    end

    for (genvar i = 0; i < PWM_NUM; i++) begin : g_ch
        logic             s_en, s_mode, s_inv;
        logic [CNT_W-1:0] s_per, s_hl, s_ph;
        logic             a_en, a_mode, a_inv;
        logic [CNT_W-1:0] a_per, a_hl, a_ph;
        logic [CNT_W-1:0] cnt;
        logic             dn, pend, pwm_q;
        logic             wr, run, bnd, apply;

        assign wr    = commit && (bcast || f_ch == 8'(i));
        assign run   = a_en && (a_per != '0);
        assign bnd   = a_mode ? (dn && cnt == '0) : (cnt == a_per - ONE);
        assign apply = pend && (!run || bnd || pwm_sync);
        assign pwm[i] = pwm_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s_en   <= 1'b0;
                s_mode <= 1'b0;
                s_inv  <= 1'b0;
                s_per  <= '0;
                s_hl   <= '0;
                s_ph   <= '0;
                a_en   <= 1'b0;
                a_mode <= 1'b0;
                a_inv  <= 1'b0;
                a_per  <= '0;
                a_hl   <= '0;
                a_ph   <= '0;
                cnt    <= '0;
                dn     <= 1'b0;
                pend   <= 1'b0;
                pwm_q  <= 1'b0;
            end else begin
                if (wr) begin
                    s_en   <= f_en;
                    s_mode <= f_mode;
                    s_inv  <= f_inv;
                    s_per  <= f_per;
                    s_hl   <= f_hl;
                    s_ph   <= word_val;
                end
                // Compare uses the settings active this cycle.
                pwm_q <= run && ((cnt < a_hl) ^ a_inv);
                pend  <= wr || (pend && !apply);
                if (apply) begin
                    a_en   <= s_en;
                    a_mode <= s_mode;
                    a_inv  <= s_inv;
                    a_per  <= s_per;
                    a_hl   <= s_hl;
                    a_ph   <= s_ph;
                    cnt    <= (s_en && s_per != '0) ? ph_mod(s_ph, s_per) : '0;
                    dn     <= 1'b0;
                end else if (!run) begin
                    cnt <= '0;
                    dn  <= 1'b0;
                end else if (pwm_sync) begin
                    cnt <= ph_mod(a_ph, a_per);
                    dn  <= 1'b0;
                end else if (!a_mode) begin
                    cnt <= (cnt == a_per - ONE) ? '0 : cnt + ONE;
                end else if (!dn) begin
                    if (cnt == a_per - ONE) dn <= 1'b1;
                    else cnt <= cnt + ONE;
                end else begin
                    if (cnt == '0) dn <= 1'b0;
                    else cnt <= cnt - ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: directed and random frames checked against a
// waveform-position model of each channel.
module tb_pwm_bank;

    localparam int         NUM = 4;
    localparam int         CW  = 28;
    localparam logic [7:0] ID  = 8'h00;

    typedef struct {
        bit          en;
        bit          mode;
        bit          inv;
        int unsigned per;
        int unsigned hl;
        int unsigned ph;
    } cfg_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    rx_axis_udp_tdata;
    logic           rx_axis_udp_tvalid;
    logic           rx_axis_udp_tlast;
    logic           pwm_sync;
    logic           cfg_ack;
    logic           cfg_err;
    logic [NUM-1:0] pwm;

    always #5 clk = ~clk;

    pwm_bank #(.PWM_NUM(NUM), .CNT_W(CW), .ID_PWM_PARAM(ID)) dut (
        .clk                (clk),
        .rst                (rst),
        .rx_axis_udp_tdata  (rx_axis_udp_tdata),
        .rx_axis_udp_tvalid (rx_axis_udp_tvalid),
        .rx_axis_udp_tlast  (rx_axis_udp_tlast),
        .pwm_sync           (pwm_sync),
        .cfg_ack            (cfg_ack),
        .cfg_err            (cfg_err),
        .pwm                (pwm)
    );

    int checks = 0;
    int errors = 0;

    // Model: each channel tracks its position within one output cycle
    // (length period, or 2*period in center mode).
    cfg_t           act  [NUM];
    cfg_t           shd  [NUM];
    bit             pend [NUM];
    int unsigned    pos  [NUM];
    logic [NUM-1:0] exp_pwm;
    logic           exp_ack, exp_err;
    bit             m_commit, m_err, m_sync;
    int             m_ch;
    cfg_t           m_cfg;

    function automatic cfg_t mk(bit en, bit mode, bit inv,
                                int unsigned per, int unsigned hl,
                                int unsigned ph);
        cfg_t c;
        c.en = en; c.mode = mode; c.inv = inv;
        c.per = per; c.hl = hl; c.ph = ph;
        return c;
    endfunction

    function automatic int unsigned start_pos(cfg_t c);
        int unsigned p;
        if (!c.en || c.per == 0) return 0;
        p = c.ph;
        if (p >= c.per) p = p - c.per;
        if (p >= c.per) p = 0;
        return p;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM; i++) begin
            act[i] = mk(0, 0, 0, 0, 0, 0);
            shd[i] = mk(0, 0, 0, 0, 0, 0);
            pend[i] = 0;
            pos[i] = 0;
        end
        exp_pwm = '0; exp_ack = 0; exp_err = 0;
        m_commit = 0; m_err = 0; m_sync = 0; m_ch = 0;
    endfunction

    function automatic void model_step();
        bit run, apply;
        int unsigned len, v;
        for (int i = 0; i < NUM; i++) begin
            run = act[i].en && act[i].per != 0;
            len = act[i].mode ? 2 * act[i].per : act[i].per;
            if (act[i].mode && pos[i] >= act[i].per) v = len - 1 - pos[i];
            else v = pos[i];
            apply = pend[i] && (!run || pos[i] == len - 1 || m_sync);
            exp_pwm[i] = run && ((v < act[i].hl) ^ act[i].inv);
            if (apply) begin
                act[i] = shd[i];
                pend[i] = 0;
                pos[i] = start_pos(shd[i]);
            end else if (!run) begin
                pos[i] = 0;
            end else if (m_sync) begin
                pos[i] = start_pos(act[i]);
            end else begin
                pos[i] = (pos[i] + 1) % len;
            end
            if (m_commit && (m_ch == 255 || m_ch == i)) begin
                shd[i] = m_cfg;
                pend[i] = 1;
            end
        end
        exp_ack = m_commit;
        exp_err = m_err;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        m_commit = 0; m_err = 0; m_sync = 0;
        #1;
    endtask

    task automatic do_sync();
        pwm_sync = 1'b1;
        m_sync = 1;
        tick();
        pwm_sync = 1'b0;
    endtask

    // kind 0: good shape, 1: tlast on word 1, 2: word 3 w/o tlast + tail
    task automatic send_frame(input logic [7:0] id, input int ch,
                              input cfg_t c, input int kind);
        logic [31:0] w [5];
        bit hit, bad;
        int n;
        hit = (id == ID);
        bad = (ch >= NUM) && (ch != 255);
        w[0] = {id, 8'(ch), 5'($urandom), c.inv, c.mode, c.en,
                8'($urandom)};
        w[1] = {4'($urandom), 28'(c.per)};
        w[2] = {4'($urandom), 28'(c.hl)};
        w[3] = {4'($urandom), 28'(c.ph)};
        w[4] = $urandom;
        n = (kind == 1) ? 2 : (kind == 2) ? 5 : 4;
        for (int k = 0; k < n; k++) begin
            rx_axis_udp_tdata = w[k];
            rx_axis_udp_tvalid = 1'b1;
            rx_axis_udp_tlast = (k == n - 1);
            if (k == n - 1 && hit) begin
                if (kind == 0 && !bad) begin
                    m_commit = 1; m_ch = ch; m_cfg = c;
                end else begin
                    m_err = 1;
                end
            end
            tick();
        end
        rx_axis_udp_tvalid = 1'b0;
        rx_axis_udp_tlast = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pwm !== '0 || cfg_ack !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reset outs pwm=%b ack=%b err=%b want 0",
                     pwm, cfg_ack, cfg_err);
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (pwm !== exp_pwm || cfg_ack !== 1'b0) begin
                errors++;
                $display("FAIL reset idle pwm=%b want %b", pwm, exp_pwm);
            end
        end
    endtask

    task automatic test_basic();
        int hi;
        hi = 0;
        send_frame(ID, 0, mk(1, 0, 0, 10, 3, 0), 0);
        checks++;
        if (cfg_ack !== 1'b1 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL basic ack got ack=%b err=%b want 1/0",
                     cfg_ack, cfg_err);
        end
        for (int k = 0; k < 40; k++) begin
            tick();
            checks++;
            if (pwm !== exp_pwm || cfg_ack !== exp_ack) begin
                errors++;
                $display("FAIL basic pwm k=%0d got %b/%b want %b/%b",
                         k, pwm, cfg_ack, exp_pwm, exp_ack);
            end
            if (k >= 20 && k < 30) hi += int'(pwm[0]);
        end
        checks++;
        if (hi != 3) begin
            errors++;
            $display("FAIL basic duty got %0d want 3", hi);
        end
    endtask

    task automatic test_update();
        int hi;
        hi = 0;
        send_frame(ID, 0, mk(1, 0, 0, 10, 7, 0), 0);
        for (int k = 0; k < 40; k++) begin
            tick();
            checks++;
            if (pwm !== exp_pwm) begin
                errors++;
                $display("FAIL update pwm k=%0d got %b want %b",
                         k, pwm, exp_pwm);
            end
            if (k >= 25 && k < 35) hi += int'(pwm[0]);
        end
        checks++;
        if (hi != 7) begin
            errors++;
            $display("FAIL update duty got %0d want 7", hi);
        end
    endtask

    task automatic test_broadcast();
        int lo [NUM];
        for (int i = 0; i < NUM; i++) lo[i] = 0;
        send_frame(ID, 255, mk(1, 1, 1, 8, 2, 0), 0);
        for (int k = 0; k < 64; k++) begin
            tick();
            checks++;
            if (pwm !== exp_pwm) begin
                errors++;
                $display("FAIL bcast pwm k=%0d got %b want %b",
                         k, pwm, exp_pwm);
            end
            if (k >= 40 && k < 56)
                for (int i = 0; i < NUM; i++) lo[i] += int'(!pwm[i]);
        end
        for (int i = 0; i < NUM; i++) begin
            checks++;
            if (lo[i] != 4) begin
                errors++;
                $display("FAIL bcast low ch%0d got %0d want 4", i, lo[i]);
            end
        end
    endtask

    task automatic test_sync_phase();
        logic r0 [30];
        logic r1 [30];
        send_frame(ID, 0, mk(1, 0, 0, 10, 3, 0), 0);
        send_frame(ID, 1, mk(1, 0, 0, 10, 3, 5), 0);
        do_sync();
        for (int k = 0; k < 30; k++) begin
            tick();
            r0[k] = pwm[0];
            r1[k] = pwm[1];
            checks++;
            if (pwm !== exp_pwm) begin
                errors++;
                $display("FAIL sync pwm k=%0d got %b want %b",
                         k, pwm, exp_pwm);
            end
        end
        for (int k = 2; k < 22; k++) begin
            checks++;
            if (r1[k] !== r0[k+5]) begin
                errors++;
                $display("FAIL sync lead k=%0d got %b want %b",
                         k, r1[k], r0[k+5]);
            end
        end
    endtask

    task automatic test_errors();
        send_frame(ID, 0, mk(1, 0, 0, 3, 1, 0), 1);
        checks++;
        if (cfg_err !== 1'b1 || cfg_ack !== 1'b0) begin
            errors++;
            $display("FAIL err short got ack=%b err=%b want 0/1",
                     cfg_ack, cfg_err);
        end
        tick();
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL err pulse got %b want 0", cfg_err);
        end
        send_frame(ID, NUM, mk(1, 0, 0, 3, 1, 0), 0);
        checks++;
        if (cfg_err !== 1'b1 || cfg_ack !== 1'b0) begin
            errors++;
            $display("FAIL err chan got ack=%b err=%b want 0/1",
                     cfg_ack, cfg_err);
        end
        send_frame(8'hA5, 0, mk(1, 0, 0, 3, 1, 0), 0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (cfg_err !== 1'b0 || cfg_ack !== 1'b0) begin
                errors++;
                $display("FAIL err id k=%0d got ack=%b err=%b want 0/0",
                         k, cfg_ack, cfg_err);
            end
            tick();
        end
        send_frame(ID, 1, mk(1, 0, 0, 3, 1, 0), 2);
        checks++;
        if (cfg_err !== 1'b1 || cfg_ack !== 1'b0) begin
            errors++;
            $display("FAIL err notlast got ack=%b err=%b want 0/1",
                     cfg_ack, cfg_err);
        end
        send_frame(ID, 2, mk(1, 0, 0, 4, 1, 0), 0);
        checks++;
        if (cfg_ack !== 1'b1 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL err good got ack=%b err=%b want 1/0",
                     cfg_ack, cfg_err);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (pwm !== exp_pwm) begin
                errors++;
                $display("FAIL err pwm k=%0d got %b want %b",
                         k, pwm, exp_pwm);
            end
        end
    endtask

    task automatic test_boundary();
        send_frame(ID, 3, mk(1, 0, 0, 6, 0, 0), 0);
        send_frame(ID, 2, mk(1, 0, 0, 6, 6, 0), 0);
        send_frame(ID, 1, mk(1, 0, 0, 0, 3, 0), 0);
        send_frame(ID, 0, mk(1, 0, 0, 5, 1, 13), 0);
        for (int k = 0; k < 40; k++) begin
            tick();
            checks++;
            if (pwm !== exp_pwm) begin
                errors++;
                $display("FAIL bound pwm k=%0d got %b want %b",
                         k, pwm, exp_pwm);
            end
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if (pwm[3:1] !== 3'b010) begin
                errors++;
                $display("FAIL bound const k=%0d got %b want 010",
                         k, pwm[3:1]);
            end
        end
        send_frame(ID, 0, mk(1, 1, 0, 5, 2, 7), 0);
        for (int k = 0; k < 24; k++) begin
            tick();
            checks++;
            if (pwm !== exp_pwm) begin
                errors++;
                $display("FAIL bound phase k=%0d got %b want %b",
                         k, pwm, exp_pwm);
            end
        end
    endtask

    task automatic test_random();
        cfg_t c;
        int r, ch, kind, gap;
        logic [7:0] id;
        for (int it = 0; it < 40; it++) begin
            c = mk($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom),
                   $urandom_range(0, 12), $urandom_range(0, 14),
                   $urandom_range(0, 30));
            r = $urandom_range(0, 9);
            id = ID;
            if (r < 6) ch = r % NUM;
            else if (r < 8) ch = 255;
            else if (r == 8) ch = $urandom_range(NUM, NUM + 2);
            else begin
                ch = $urandom_range(0, NUM - 1);
                id = 8'h5A;
            end
            r = $urandom_range(0, 9);
            kind = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            send_frame(id, ch, c, kind);
            checks++;
            if (cfg_ack !== exp_ack || cfg_err !== exp_err) begin
                errors++;
                $display("FAIL rand resp it=%0d got %b%b want %b%b",
                         it, cfg_ack, cfg_err, exp_ack, exp_err);
            end
            gap = $urandom_range(1, 12);
            if ($urandom_range(0, 4) == 0) do_sync();
            for (int k = 0; k < gap; k++) begin
                tick();
                checks++;
                if (pwm !== exp_pwm || cfg_ack !== exp_ack ||
                    cfg_err !== exp_err) begin
                    errors++;
                    $display("FAIL rand pwm it=%0d got %b want %b",
                             it, pwm, exp_pwm);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        rx_axis_udp_tdata = {ID, 8'd1, 16'h0100};
        rx_axis_udp_tvalid = 1'b1;
        rx_axis_udp_tlast = 1'b0;
        tick();
        rx_axis_udp_tdata = 32'd9;
        tick();
        rx_axis_udp_tvalid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (pwm !== '0 || cfg_ack !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst outs pwm=%b ack=%b err=%b want 0",
                     pwm, cfg_ack, cfg_err);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_frame(ID, 2, mk(1, 0, 0, 4, 2, 1), 0);
        checks++;
        if (cfg_ack !== 1'b1 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst ack got ack=%b err=%b want 1/0",
                     cfg_ack, cfg_err);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (pwm !== exp_pwm) begin
                errors++;
                $display("FAIL midrst pwm k=%0d got %b want %b",
                         k, pwm, exp_pwm);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        rx_axis_udp_tdata = '0;
        rx_axis_udp_tvalid = 1'b0;
        rx_axis_udp_tlast = 1'b0;
        pwm_sync = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_update();
        test_broadcast();
        test_sync_phase();
        test_errors();
        test_boundary();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
